// File: rtl/device_dna_pkg.sv
// Shared definitions for the device DNA reader: register offsets, STATUS layout,
// CtrlPort response codes and the shifter state encoding.
package device_dna_pkg;

   localparam logic [5:0] DNA_WORD0 = 6'h00;
   localparam logic [5:0] STATUS    = 6'h20;
   localparam logic [5:0] CONTROL   = 6'h24;

   localparam int STATUS_VALID_BIT = 0;
   localparam int STATUS_BUSY_BIT  = 1;
   localparam int STATUS_COUNT_LSB = 8;
   localparam int STATUS_WIDTH_LSB = 16;

   localparam int MAX_DNA_WIDTH = 256;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_CMDERR = 2'b01,
      RESP_SLVERR = 2'b11
   } resp_status_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } dna_state_t;

   function automatic int num_words(input int width);
      return (width + 31) / 32;
   endfunction

endpackage

// File: rtl/device_dna_shifter.sv
// Drives the DNA shift-port primitive and assembles the serial ID into a register.
//
//   state    | meaning
//   ST_IDLE  | just out of reset, launches the first read on the next edge
//   ST_LOAD  | dna_read high for one cycle, primitive latches its ID
//   ST_SHIFT | dna_shift high, one dout bit captured per cycle
//   ST_DONE  | ID captured and valid, waits for a re-read request
module device_dna_shifter
   import device_dna_pkg::*;
#(
   parameter int DNA_WIDTH = 96,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 clk_sys,
   input  logic                 rst_b,
   input  logic                 start,
   input  logic                 dna_dout,
   output logic                 dna_read,
   output logic                 dna_shift,
   output logic                 valid,
   output logic                 busy,
   output logic                 done,
   output logic [DNA_WIDTH-1:0] id
);

   localparam int              CNT_W    = $clog2(DNA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_WIDTH - 1);

   dna_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] bit_idx;

   // cnt runs down from DNA_WIDTH-1, so it is already the MSB-first bit index
   assign bit_idx = MSB_FIRST ? cnt : (CNT_LAST - cnt);
   assign busy    = (state == ST_LOAD) || (state == ST_SHIFT);
   assign done    = (state == ST_SHIFT) && (cnt == '0);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         id        <= '0;
         valid     <= 1'b0;
         dna_read  <= 1'b0;
         dna_shift <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_LOAD;
               dna_read <= 1'b1;
            end
            ST_LOAD: begin
               state     <= ST_SHIFT;
               dna_read  <= 1'b0;
               dna_shift <= 1'b1;
               cnt       <= CNT_LAST;
            end
            ST_SHIFT: begin
               for (int i = 0; i < DNA_WIDTH; i++) begin
                  if (CNT_W'(i) == bit_idx) id[i] <= dna_dout;
               end
               if (cnt == '0) begin
                  state     <= ST_DONE;
                  dna_shift <= 1'b0;
                  valid     <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (start) begin
                  state    <= ST_LOAD;
                  dna_read <= 1'b1;
                  valid    <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/device_dna_reader.sv
// CtrlPort register window serving the device DNA, read status and a re-read control.
// The shift-port primitive lives outside and shares ctrlport_clk.
module device_dna_reader
   import device_dna_pkg::*;
#(
   parameter int BASE_ADDR = 0,
   parameter int DNA_WIDTH = 96,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        ctrlport_clk,
   input  logic        reset_n,
   input  logic        s_ctrlport_req_wr,
   input  logic        s_ctrlport_req_rd,
   input  logic [19:0] s_ctrlport_req_addr,
   input  logic [31:0] s_ctrlport_req_data,
   output logic        s_ctrlport_resp_ack,
   output logic [1:0]  s_ctrlport_resp_status,
   output logic [31:0] s_ctrlport_resp_data,
   output logic        dna_read,
   output logic        dna_shift,
   input  logic        dna_dout
);

   localparam int          NUM_WORDS = num_words(DNA_WIDTH);
   localparam logic [19:0] BASE_W    = 20'(BASE_ADDR);

   logic [DNA_WIDTH-1:0]     id;
   logic [MAX_DNA_WIDTH-1:0] id_ext;
   logic                     valid;
   logic                     busy;
   logic                     done;
   logic                     start;
   logic [7:0]               read_count;
   logic                     req;
   logic                     in_window;
   logic [3:0]               word_idx;
   logic [5:0]               offset;
   logic [31:0]              status_word;
   resp_status_t             rsp_status;
   logic [31:0]              rsp_data;
   logic                     unused_req_bits;

   assign req       = s_ctrlport_req_wr | s_ctrlport_req_rd;
   assign in_window = (s_ctrlport_req_addr[19:6] == BASE_W[19:6]);
   assign word_idx  = s_ctrlport_req_addr[5:2];
   assign offset    = {word_idx, 2'b00};
   // write wins over read, so a combined strobe can still launch a re-read
   assign start     = s_ctrlport_req_wr && in_window && (offset == CONTROL)
                      && s_ctrlport_req_data[0];
   assign unused_req_bits = ^{s_ctrlport_req_data[31:1], s_ctrlport_req_addr[1:0]};

   device_dna_shifter #(
      .DNA_WIDTH (DNA_WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clk_sys   (ctrlport_clk),
      .rst_b     (reset_n),
      .start     (start),
      .dna_dout  (dna_dout),
      .dna_read  (dna_read),
      .dna_shift (dna_shift),
      .valid     (valid),
      .busy      (busy),
      .done      (done),
      .id        (id)
   );

   always_comb begin
      id_ext                = '0;
      id_ext[DNA_WIDTH-1:0] = id;
      status_word                              = '0;
      status_word[STATUS_VALID_BIT]            = valid;
      status_word[STATUS_BUSY_BIT]             = busy;
      status_word[STATUS_COUNT_LSB +: 8]       = read_count;
      status_word[STATUS_WIDTH_LSB +: 16]      = 16'(DNA_WIDTH);
   end

   always_comb begin
      rsp_status = RESP_SLVERR;
      rsp_data   = '0;
      if (offset >= DNA_WORD0 && word_idx < 4'(NUM_WORDS)) begin
         if (!s_ctrlport_req_wr) begin
            if (!valid) begin
               rsp_status = RESP_CMDERR;
            end else begin
               rsp_status = RESP_OKAY;
               rsp_data   = id_ext[{word_idx[2:0], 5'b00000} +: 32];
            end
         end
      end else if (offset == STATUS) begin
         if (!s_ctrlport_req_wr) begin
            rsp_status = RESP_OKAY;
            rsp_data   = status_word;
         end
      end else if (offset == CONTROL) begin
         rsp_status = RESP_OKAY;
      end
   end

   always_ff @(posedge ctrlport_clk or negedge reset_n) begin
      if (!reset_n) begin
         s_ctrlport_resp_ack    <= 1'b0;
         s_ctrlport_resp_status <= 2'b00;
         s_ctrlport_resp_data   <= '0;
         read_count             <= '0;
      end else begin
         s_ctrlport_resp_ack <= req && in_window;
         if (req && in_window) begin
            s_ctrlport_resp_status <= rsp_status;
            s_ctrlport_resp_data   <= rsp_data;
         end else begin
            s_ctrlport_resp_status <= 2'b00;
            s_ctrlport_resp_data   <= '0;
         end
         if (done) read_count <= read_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_device_dna_reader.sv
// Directed bench: a 96-bit LSB-first reader at 0x0000 and a 57-bit MSB-first reader
// at 0x1000, each fed by a behavioural DNA shift-port model.
module tb_device_dna_reader;

   localparam logic [95:0] ID96_A = 96'h012F1110_C0D111A0_11C0FFEE;
   localparam logic [95:0] ID96_B = 96'hDEADBEEF_01234567_89ABCDEF;
   localparam logic [56:0] ID57   = 57'h0_00D1_11A0_C0DE_00FF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_wr, req_rd;
   logic [19:0] req_addr;
   logic [31:0] req_data;
   logic        ack96, ack57;
   logic [1:0]  st96, st57;
   logic [31:0] d96, d57;
   logic        rd96, sh96, do96, rd57, sh57, do57;

   logic [95:0] m96_id, m96_sr;
   logic [56:0] m57_id, m57_sr;

   int total = 0;
   int bad   = 0;
   int cyc;

   logic        b_ack;
   logic [1:0]  b_st;
   logic [31:0] b_data;

   always #5 clk = ~clk;

   device_dna_reader #(.BASE_ADDR(0), .DNA_WIDTH(96), .MSB_FIRST(1'b0)) u_dna96 (
      .ctrlport_clk           (clk),
      .reset_n                (reset_n),
      .s_ctrlport_req_wr      (req_wr),
      .s_ctrlport_req_rd      (req_rd),
      .s_ctrlport_req_addr    (req_addr),
      .s_ctrlport_req_data    (req_data),
      .s_ctrlport_resp_ack    (ack96),
      .s_ctrlport_resp_status (st96),
      .s_ctrlport_resp_data   (d96),
      .dna_read               (rd96),
      .dna_shift              (sh96),
      .dna_dout               (do96)
   );

   device_dna_reader #(.BASE_ADDR(32'h1000), .DNA_WIDTH(57), .MSB_FIRST(1'b1)) u_dna57 (
      .ctrlport_clk           (clk),
      .reset_n                (reset_n),
      .s_ctrlport_req_wr      (req_wr),
      .s_ctrlport_req_rd      (req_rd),
      .s_ctrlport_req_addr    (req_addr),
      .s_ctrlport_req_data    (req_data),
      .s_ctrlport_resp_ack    (ack57),
      .s_ctrlport_resp_status (st57),
      .s_ctrlport_resp_data   (d57),
      .dna_read               (rd57),
      .dna_shift              (sh57),
      .dna_dout               (do57)
   );

   // primitive models: load on dna_read, shift on dna_shift, dout is the head bit
   always @(posedge clk) begin
      if (rd96)      m96_sr <= m96_id;
      else if (sh96) m96_sr <= {1'b0, m96_sr[95:1]};
      if (rd57)      m57_sr <= m57_id;
      else if (sh57) m57_sr <= {m57_sr[55:0], 1'b0};
   end
   assign do96 = m96_sr[0];
   assign do57 = m57_sr[56];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic bus(input logic wr, input logic rd, input logic [19:0] a,
                      input logic [31:0] d, input logic sel57);
      @(posedge clk); #1;
      req_wr = wr; req_rd = rd; req_addr = a; req_data = d;
      @(posedge clk); #1;
      req_wr = 1'b0; req_rd = 1'b0;
      b_ack  = sel57 ? ack57 : ack96;
      b_st   = sel57 ? st57  : st96;
      b_data = sel57 ? d57   : d96;
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      req_wr = 1'b0; req_rd = 1'b0; req_addr = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({ack96, st96, d96, rd96, sh96} !== 37'd0) begin
         bad++; $display("FAIL reset_outputs96 got=%h exp=0", {ack96, st96, d96, rd96, sh96});
      end
      total++;
      if ({ack57, st57, d57, rd57, sh57} !== 37'd0) begin
         bad++; $display("FAIL reset_outputs57 got=%h exp=0", {ack57, st57, d57, rd57, sh57});
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({rd96, sh96} !== 2'b10) begin
         bad++; $display("FAIL load_cycle1 got=%b exp=10", {rd96, sh96});
      end
      @(posedge clk); #1;
      total++;
      if ({rd96, sh96} !== 2'b01) begin
         bad++; $display("FAIL shift_cycle2 got=%b exp=01", {rd96, sh96});
      end
   endtask

   task automatic test_first_read;
      wait_cyc(10);
      bus(1'b0, 1'b1, 20'h00000, 32'd0, 1'b0);
      total++;
      if ({b_ack, b_st, b_data} !== {1'b1, 2'b01, 32'd0}) begin
         bad++; $display("FAIL early_word_cmderr got=%h exp=%h", {b_ack, b_st, b_data}, {1'b1, 2'b01, 32'd0});
      end
      wait_cyc(58);
      total++;
      if (sh57 !== 1'b1) begin bad++; $display("FAIL shift57_last got=%b exp=1", sh57); end
      wait_cyc(59);
      total++;
      if (sh57 !== 1'b0) begin bad++; $display("FAIL shift57_end got=%b exp=0", sh57); end
      wait_cyc(97);
      total++;
      if (sh96 !== 1'b1) begin bad++; $display("FAIL shift96_last got=%b exp=1", sh96); end
      wait_cyc(98);
      total++;
      if (sh96 !== 1'b0) begin bad++; $display("FAIL shift96_end got=%b exp=0", sh96); end
   endtask

   task automatic test_id_words;
      logic [19:0] a_tab [7] = '{20'h00000, 20'h00004, 20'h00008, 20'h00020,
                                 20'h01000, 20'h01004, 20'h01020};
      logic [31:0] e_tab [7] = '{32'h11C0FFEE, 32'hC0D111A0, 32'h012F1110, 32'h0060_0101,
                                 32'hC0DE00FF, 32'h00D111A0, 32'h0039_0101};
      for (int i = 0; i < 7; i++) begin
         bus(1'b0, 1'b1, a_tab[i], 32'd0, a_tab[i][12]);
         total++;
         if ({b_ack, b_st, b_data} !== {1'b1, 2'b00, e_tab[i]}) begin
            bad++; $display("FAIL id_word[%0d] addr=%h got=%h exp=%h", i, a_tab[i],
                            {b_ack, b_st, b_data}, {1'b1, 2'b00, e_tab[i]});
         end
      end
      @(posedge clk); #1;
      total++;
      if (ack57 !== 1'b0) begin bad++; $display("FAIL ack_one_cycle got=%b exp=0", ack57); end
   endtask

   task automatic test_errors;
      logic seen;
      logic [19:0] a_tab [5] = '{20'h00000, 20'h00010, 20'h01008, 20'h00020, 20'h00028};
      logic        w_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         bus(w_tab[i], !w_tab[i], a_tab[i], 32'hFFFF_FFFF, a_tab[i][12]);
         total++;
         if ({b_ack, b_st, b_data} !== {1'b1, 2'b11, 32'd0}) begin
            bad++; $display("FAIL slverr[%0d] addr=%h got=%h exp=%h", i, a_tab[i],
                            {b_ack, b_st, b_data}, {1'b1, 2'b11, 32'd0});
         end
      end
      bus(1'b0, 1'b1, 20'h00040, 32'd0, 1'b0);
      seen = b_ack | ack57;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         seen = seen | ack96 | ack57;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL out_of_window_ack got=%b exp=0", seen); end
   endtask

   task automatic test_reread;
      int t0;
      m96_id = ID96_B;
      bus(1'b1, 1'b0, 20'h00024, 32'd1, 1'b0);
      t0 = cyc;
      total++;
      if ({b_ack, b_st, rd96} !== {1'b1, 2'b00, 1'b1}) begin
         bad++; $display("FAIL reread_write got=%b exp=1001", {b_ack, b_st, rd96});
      end
      bus(1'b0, 1'b1, 20'h00020, 32'd0, 1'b0);
      total++;
      if ({b_ack, b_st, b_data} !== {1'b1, 2'b00, 32'h0060_0102}) begin
         bad++; $display("FAIL status_busy got=%h exp=%h", {b_ack, b_st, b_data}, {1'b1, 2'b00, 32'h0060_0102});
      end
      bus(1'b1, 1'b0, 20'h00024, 32'd1, 1'b0);
      total++;
      if ({b_ack, b_st} !== 3'b100) begin
         bad++; $display("FAIL busy_reread_ack got=%b exp=100", {b_ack, b_st});
      end
      bus(1'b0, 1'b1, 20'h00008, 32'd0, 1'b0);
      total++;
      if ({b_ack, b_st, b_data} !== {1'b1, 2'b01, 32'd0}) begin
         bad++; $display("FAIL busy_word_cmderr got=%h exp=%h", {b_ack, b_st, b_data}, {1'b1, 2'b01, 32'd0});
      end
      wait_cyc(t0 + 96);
      total++;
      if (sh96 !== 1'b1) begin bad++; $display("FAIL reread_shift_last got=%b exp=1", sh96); end
      wait_cyc(t0 + 97);
      total++;
      if (sh96 !== 1'b0) begin bad++; $display("FAIL reread_shift_end got=%b exp=0", sh96); end
      bus(1'b0, 1'b1, 20'h00020, 32'd0, 1'b0);
      total++;
      if ({b_ack, b_st, b_data} !== {1'b1, 2'b00, 32'h0060_0201}) begin
         bad++; $display("FAIL reread_status got=%h exp=%h", {b_ack, b_st, b_data}, {1'b1, 2'b00, 32'h0060_0201});
      end
      for (int i = 0; i < 3; i++) begin
         bus(1'b0, 1'b1, 20'(4 * i), 32'd0, 1'b0);
         total++;
         if ({b_ack, b_st, b_data} !== {1'b1, 2'b00, ID96_B[32*i +: 32]}) begin
            bad++; $display("FAIL reread_word[%0d] got=%h exp=%h", i, {b_ack, b_st, b_data},
                            {1'b1, 2'b00, ID96_B[32*i +: 32]});
         end
      end
   endtask

   task automatic test_rdwr;
      int t0;
      bus(1'b1, 1'b1, 20'h00024, 32'd1, 1'b0);
      t0 = cyc;
      total++;
      if ({b_ack, b_st, b_data, rd96} !== {1'b1, 2'b00, 32'd0, 1'b1}) begin
         bad++; $display("FAIL rdwr_control got=%h exp=%h", {b_ack, b_st, b_data, rd96},
                         {1'b1, 2'b00, 32'd0, 1'b1});
      end
      @(posedge clk); #1;
      total++;
      if (ack96 !== 1'b0) begin bad++; $display("FAIL rdwr_single_ack got=%b exp=0", ack96); end
      wait_cyc(t0 + 97);
      bus(1'b0, 1'b1, 20'h00020, 32'd0, 1'b0);
      total++;
      if ({b_ack, b_st, b_data} !== {1'b1, 2'b00, 32'h0060_0301}) begin
         bad++; $display("FAIL rdwr_status got=%h exp=%h", {b_ack, b_st, b_data}, {1'b1, 2'b00, 32'h0060_0301});
      end
   endtask

   task automatic test_reset_mid_shift;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      wait_cyc(40);
      total++;
      if (sh96 !== 1'b1) begin bad++; $display("FAIL mid_shift_active got=%b exp=1", sh96); end
      reset_n = 1'b0;
      #2;
      total++;
      if ({ack96, st96, d96, rd96, sh96, ack57, st57, d57, rd57, sh57} !== 74'd0) begin
         bad++; $display("FAIL mid_reset_outputs got=%h exp=0",
                         {ack96, st96, d96, rd96, sh96, ack57, st57, d57, rd57, sh57});
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({rd96, sh96} !== 2'b10) begin bad++; $display("FAIL restart_load got=%b exp=10", {rd96, sh96}); end
      wait_cyc(98);
      bus(1'b0, 1'b1, 20'h00020, 32'd0, 1'b0);
      total++;
      if ({b_ack, b_st, b_data} !== {1'b1, 2'b00, 32'h0060_0101}) begin
         bad++; $display("FAIL restart_status got=%h exp=%h", {b_ack, b_st, b_data}, {1'b1, 2'b00, 32'h0060_0101});
      end
      for (int i = 0; i < 3; i++) begin
         bus(1'b0, 1'b1, 20'(4 * i), 32'd0, 1'b0);
         total++;
         if ({b_ack, b_st, b_data} !== {1'b1, 2'b00, ID96_B[32*i +: 32]}) begin
            bad++; $display("FAIL restart_word[%0d] got=%h exp=%h", i, {b_ack, b_st, b_data},
                            {1'b1, 2'b00, ID96_B[32*i +: 32]});
         end
      end
   endtask

   initial begin
      m96_id = ID96_A;
      m57_id = ID57;
      test_reset();
      test_first_read();
      test_id_words();
      test_errors();
      test_reread();
      test_rdwr();
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/device_dna_reader.md
# device_dna_reader

Parametrised successor to the device DNA CtrlPort block. It drives an external DNA shift-port primitive (7-series DNA_PORT, UltraScale DNA_PORTE2) through its read/shift/dout pins. It captures an ID of any width up to 256 bits and serves it, with status and an on-demand re-read, over a CtrlPort register window. It sits on the motherboard CtrlPort bus next to other identification registers. The primitive is instantiated outside the block and shares ctrlport_clk.

## Interface
Parameters:
- BASE_ADDR, 0: byte address of register window, 64-byte aligned
- DNA_WIDTH, 96: ID bits, 1..256
- MSB_FIRST, 0: 1 = first dout bit is ID bit DNA_WIDTH-1; 0 = first bit is bit 0

Ports:
- ctrlport_clk  in  1  sole clock; also clocks the primitive
- reset_n  in  1  asynchronous, active-low reset; deassertion is synchronised to ctrlport_clk upstream
- s_ctrlport_req_wr  in  1  write strobe
- s_ctrlport_req_rd  in  1  read strobe
- s_ctrlport_req_addr  in  20  byte address
- s_ctrlport_req_data  in  32  write data
- s_ctrlport_resp_ack  out  1  response strobe
- s_ctrlport_resp_status  out  2  00 OKAY, 01 CMDERR (ID not valid), 11 SLVERR (unmapped/read-only)
- s_ctrlport_resp_data  out  32  read data
- dna_read  out  1  load pulse to primitive
- dna_shift  out  1  shift enable to primitive
- dna_dout  in  1  serial ID bit from primitive

## Operation
- Register map (offsets from BASE_ADDR):
  - 0x00 + 4*i: DNA word i, i < NUM_WORDS = ceil(DNA_WIDTH/32); word i = ID[32i+31:32i]; unused upper bits of the last word read 0.
  - 0x20: STATUS (RO). Bit0 VALID; bit1 BUSY; [15:8] READ_COUNT (completed reads, wraps 255->0); [31:16] DNA_WIDTH constant.
  - 0x24: CONTROL. Write bit0 = 1 requests re-read; reads return 0.
- Window is BASE_ADDR..BASE_ADDR+0x3F; addresses outside get no ack.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - Reset state is IDLE.
  - IDLE -> LOAD unconditionally on the first edge after reset release.
  - LOAD: dna_read=1 for one cycle.
  - SHIFT: dna_shift=1 for DNA_WIDTH cycles; each cycle samples dna_dout into the bit selected by MSB_FIRST and an internal bit counter.
  - SHIFT -> DONE after the DNA_WIDTH-th sample; VALID is set and READ_COUNT increments.
  - DONE -> LOAD on a CONTROL write with bit0=1; VALID clears in the same edge.
  - A re-read request while BUSY is ignored and the write still acks OKAY.
- BUSY = state in {LOAD, SHIFT}.
- DNA word read while VALID=0: status CMDERR, data 0. The ID register holds its previous contents but is not exposed.
- Write to DNA words or STATUS, read/write to an unmapped in-window offset: SLVERR, data 0.
- Simultaneous rd and wr: treated as write; exactly one ack.
- Reset mid-shift: all state returns to reset values immediately; the sequence restarts from LOAD after release.

## Timing
- Reset values: resp_ack=0, resp_status=00, resp_data=0, dna_read=0, dna_shift=0; ID register=0, VALID=0, BUSY=0, READ_COUNT=0.
- Let cycle 1 be the first ctrlport_clk edge after reset_n deasserts:
  - LOAD is during cycle 1.
  - SHIFT occupies cycles 2..DNA_WIDTH+1.
  - VALID=1 is visible from cycle DNA_WIDTH+2.
- CtrlPort latency: ack asserts exactly one cycle after the request strobe and lasts one cycle. Back-to-back requests each get one ack.
- Re-read: CONTROL write at cycle t -> LOAD at t+1; VALID again at t+DNA_WIDTH+2.
- No ctrlport outputs are combinational from inputs.

## Structure
- Package device_dna_pkg:
  - register offsets (DNA_WORD0, STATUS=0x20, CONTROL=0x24)
  - STATUS bit positions
  - ctrlport status codes
  - FSM state enum
- Sub-module device_dna_shifter: owns the FSM, bit counter, ID register and primitive pins. It outputs id, valid, busy and a done pulse, and takes a start request.
- The top level contains CtrlPort decode, READ_COUNT, and the response mux.

## Test plan
Bench uses a behavioural primitive model that loads on dna_read and shifts on dna_shift.
- DNA_WIDTH=96, MSB_FIRST=0, ID 96'h012F1110_C0D111A0_11C0FFEE. Read offset 0x00 twelve cycles after reset -> CMDERR, data 0. After completion, 0x00/0x04/0x08 -> 11C0FFEE/C0D111A0/012F1110 OKAY; 0x20 -> 0x0060_0101.
- DNA_WIDTH=57, MSB_FIRST=1, ID 57'h0_00D1_11A0_C0DE_00FF -> 0x00=C0DE00FF, 0x04=00D111A0 (upper bits zero).
- Model ID changed, CONTROL write 1:
  - STATUS immediately shows BUSY=1, VALID=0.
  - After 98 cycles, new ID is readable and READ_COUNT=2.
  - Second CONTROL write while BUSY leaves READ_COUNT unchanged at completion.
- reset_n pulsed low mid-SHIFT (cycle 40):
  - all outputs are zero during reset.
  - After release, the full sequence completes with the correct ID and READ_COUNT=1.
- Error paths:
  - write to 0x00 -> SLVERR.
  - read 0x10 with DNA_WIDTH=96 -> SLVERR.
  - read BASE_ADDR+0x40 -> no ack within 10 cycles.
  - simultaneous rd+wr to CONTROL -> single OKAY ack and re-read starts.
